// File: rtl/spi_stream_unpacker.sv
// Purpose: pops 32-bit loader words and streams them out one byte at a time, LSB first.
// Latency: first byte valid 1 cycle after FETCH sees a word; 4 bytes per 5 cycles at full rate.
// Backpressure: o_data/o_valid hold while i_ready is low; no pop until the current word is drained.
module spi_stream_unpacker #(
  parameter int MAX_BYTES = 8192,
  parameter int CNT_W     = 14
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_byte_count,
  output logic             o_fill,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd,
  input  logic [31:0]      i_fifo_dout,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  state_t           state, state_nxt;
  logic [31:0]      shift_q, shift_nxt;
  logic [CNT_W-1:0] bytes_left, bytes_nxt;
  logic [1:0]       byte_idx, idx_nxt;
  logic             valid_nxt;
  logic             rd_nxt;
  logic             fill_nxt;
  logic             done_nxt;

  // Bytes always leave from the bottom of the shift register.
  assign o_data = shift_q[7:0];

  // Next-state and next-output logic; abort overrides everything and never raises done.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    bytes_nxt = bytes_left;
    idx_nxt   = byte_idx;
    valid_nxt = o_valid;
    rd_nxt    = 1'b0;
    if (i_abort) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_byte_count == '0) begin
              state_nxt = DONE;
            end else begin
              bytes_nxt = (i_byte_count > MAX_CNT) ? MAX_CNT : i_byte_count;
              idx_nxt   = 2'd0;
              state_nxt = FETCH;
            end
          end
        end
        FETCH: begin
          // The pop strobe rises together with the first byte; the loader only
          // advances its output the cycle after, so the word is already captured.
          if (!i_fifo_empty) begin
            shift_nxt = i_fifo_dout;
            rd_nxt    = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (o_valid && i_ready) begin
            bytes_nxt = bytes_left - CNT_W'(1);
            if (bytes_left == CNT_W'(1)) begin
              // Last byte of the stream; any remaining bytes of this word are dropped.
              valid_nxt = 1'b0;
              state_nxt = DONE;
            end else if (byte_idx == 2'd3) begin
              valid_nxt = 1'b0;
              idx_nxt   = 2'd0;
              state_nxt = FETCH;
            end else begin
              shift_nxt = {8'h00, shift_q[31:8]};
              idx_nxt   = byte_idx + 2'd1;
            end
          end
        end
        DONE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
    fill_nxt = (state_nxt == FETCH) || (state_nxt == SHIFT);
    done_nxt = (state_nxt == DONE);
  end

  // State, datapath and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      shift_q    <= '0;
      bytes_left <= '0;
      byte_idx   <= 2'd0;
      o_valid    <= 1'b0;
      o_fifo_rd  <= 1'b0;
      o_fill     <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_q    <= shift_nxt;
      bytes_left <= bytes_nxt;
      byte_idx   <= idx_nxt;
      o_valid    <= valid_nxt;
      o_fifo_rd  <= rd_nxt;
      o_fill     <= fill_nxt;
      o_busy     <= fill_nxt;
      o_done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_spi_stream_unpacker.sv
// Scoreboard bench for spi_stream_unpacker: expected bytes are queued by the
// stimulus, a separate monitor pops them on every handshake and also tracks
// pops, done pulses, pop spacing and stall stability.
module tb_spi_stream_unpacker;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_start;
  logic        i_abort;
  logic [13:0] i_byte_count;
  logic        o_fill;
  logic        i_fifo_empty;
  logic        o_fifo_rd;
  logic [31:0] i_fifo_dout;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;
  logic        o_done;

  spi_stream_unpacker dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_byte_count (i_byte_count),
    .o_fill       (o_fill),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rd    (o_fifo_rd),
    .i_fifo_dout  (i_fifo_dout),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  // Loader buffer model: read pointer rewinds while fill is low.
  localparam int MEM_N = 2100;
  logic [31:0] mem [0:MEM_N-1];
  int          nwords = 0;
  int          rptr = 0;
  logic        force_empty = 1'b0;

  always @(posedge clk) begin
    if (!o_fill) rptr <= 0;
    else if (o_fifo_rd) rptr <= rptr + 1;
  end

  assign i_fifo_empty = force_empty || (rptr >= nwords);
  assign i_fifo_dout  = (rptr < MEM_N) ? mem[rptr] : 32'h0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  int pop_cnt = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int last_hs_cyc = 0;
  int done_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares each accepted byte against the scoreboard.
  initial begin : monitor
    bit         stalled;
    bit         have_pop;
    int         last_pop_cyc;
    logic [7:0] stall_data;
    logic [7:0] e;
    stalled = 0;
    have_pop = 0;
    last_pop_cyc = 0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (stalled) begin
          chk("stall_hold_valid", {31'b0, o_valid}, 32'd1);
          chk("stall_hold_data", {24'b0, o_data}, {24'b0, stall_data});
        end
        if (o_valid && i_ready) begin
          hs_cnt++;
          last_hs_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", o_data);
          end else begin
            e = exp_q.pop_front();
            chk("byte", {24'b0, o_data}, {24'b0, e});
          end
        end
        if (o_fifo_rd) begin
          pop_cnt++;
          if (have_pop) chk("pop_gap_ge5", {31'b0, (cyc - last_pop_cyc) >= 5}, 32'd1);
          have_pop = 1;
          last_pop_cyc = cyc;
        end
        if (o_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        stalled = o_valid && !i_ready && !i_abort;
        stall_data = o_data;
      end else begin
        stalled = 0;
      end
    end
  end

  task automatic push_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic load2(input logic [31:0] w0, input logic [31:0] w1);
    mem[0] = w0;
    mem[1] = w1;
    nwords = 2;
  endtask

  task automatic start_stream(input int cnt, output int s);
    @(posedge clk);
    #1 i_start = 1'b1;
    i_byte_count = 14'(cnt);
    @(posedge clk);
    #1 i_start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      if (done_cnt != d0) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  task automatic wait_byte(input string name, input logic [7:0] b, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (o_valid && o_data == b) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout actual=no_byte required=%0h", name, b);
    end
  endtask

  // Plain 8-byte stream over two words with full-rate downstream.
  task automatic run8(input string name);
    int s, p0, d0;
    load2(32'h44332211, 32'h88776655);
    push_word(32'h44332211, 4);
    push_word(32'h88776655, 4);
    i_ready = 1'b1;
    p0 = pop_cnt;
    d0 = done_cnt;
    start_stream(8, s);
    wait_done(name, 100);
    chk({name, "_pops"}, pop_cnt - p0, 2);
    chk({name, "_done_after_last_hs"}, done_cyc - last_hs_cyc, 1);
    chk({name, "_cycles"}, done_cyc - s, 10);
    @(negedge clk);
    chk({name, "_fill_low"}, {31'b0, o_fill}, 0);
    chk({name, "_done_once"}, done_cnt - d0, 1);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic run5(input string name);
    int s, p0, d0;
    load2(32'h44332211, 32'h88776655);
    push_word(32'h44332211, 4);
    push_word(32'h88776655, 1);
    i_ready = 1'b1;
    p0 = pop_cnt;
    d0 = done_cnt;
    start_stream(5, s);
    wait_done(name, 100);
    chk({name, "_pops"}, pop_cnt - p0, 2);
    chk({name, "_done_after_last_hs"}, done_cyc - last_hs_cyc, 1);
    chk({name, "_cycles"}, done_cyc - s, 7);
    @(negedge clk);
    chk({name, "_valid_low"}, {31'b0, o_valid}, 0);
    chk({name, "_done_once"}, done_cnt - d0, 1);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin : stim
    int s, p0, d0, h0;
    bit bad;
    resetn = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_byte_count = '0;
    i_ready = 1'b1;
    for (int i = 0; i < MEM_N; i++) mem[i] = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, o_valid}, 0);
    chk("rst_fill", {31'b0, o_fill}, 0);
    chk("rst_busy", {31'b0, o_busy}, 0);
    chk("rst_done", {31'b0, o_done}, 0);
    chk("rst_rd", {31'b0, o_fifo_rd}, 0);
    chk("rst_data", {24'b0, o_data}, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);

    // Full 8-byte stream
    run8("t1");
    repeat (6) @(posedge clk);

    // Partial final word
    run5("t2");
    repeat (6) @(posedge clk);

    // Downstream stall on byte 22
    load2(32'h44332211, 32'h88776655);
    push_word(32'h44332211, 4);
    push_word(32'h88776655, 4);
    i_ready = 1'b1;
    p0 = pop_cnt;
    start_stream(8, s);
    wait_byte("t3_first", 8'h11, 20);
    @(posedge clk);
    #1 i_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_stall_valid", {31'b0, o_valid}, 1);
    chk("t3_stall_data", {24'b0, o_data}, 32'h22);
    @(posedge clk);
    #1 i_ready = 1'b1;
    wait_done("t3", 100);
    chk("t3_pops", pop_cnt - p0, 2);
    chk("t3_cycles", done_cyc - s, 13);
    chk("t3_queue_drained", exp_q.size(), 0);
    repeat (6) @(posedge clk);

    // Loader empty for 20 cycles
    mem[0] = 32'h44332211;
    nwords = 1;
    push_word(32'h44332211, 4);
    force_empty = 1'b1;
    p0 = pop_cnt;
    start_stream(4, s);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(o_fill && o_busy && !o_fifo_rd && !o_valid)) bad = 1;
    end
    chk("t4_wait_fill_busy_no_pop", {31'b0, bad}, 0);
    @(posedge clk);
    #1 force_empty = 1'b0;
    @(negedge clk);
    chk("t4_valid_not_early", {31'b0, o_valid}, 0);
    @(negedge clk);
    chk("t4_valid_next_cycle", {31'b0, o_valid}, 1);
    chk("t4_first_byte", {24'b0, o_data}, 32'h11);
    wait_done("t4", 100);
    chk("t4_pops", pop_cnt - p0, 1);
    chk("t4_queue_drained", exp_q.size(), 0);
    repeat (6) @(posedge clk);

    // Zero count
    d0 = done_cnt;
    p0 = pop_cnt;
    start_stream(0, s);
    @(negedge clk);
    chk("t5_done_high", {31'b0, o_done}, 1);
    chk("t5_fill_low", {31'b0, o_fill}, 0);
    @(negedge clk);
    chk("t5_done_one_cycle", {31'b0, o_done}, 0);
    chk("t5_fill_still_low", {31'b0, o_fill}, 0);
    @(posedge clk);
    chk("t5_done_once", done_cnt - d0, 1);
    chk("t5_no_pops", pop_cnt - p0, 0);
    repeat (6) @(posedge clk);

    // Count above the ceiling
    for (int k = 0; k < MEM_N; k++)
      mem[k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    nwords = MEM_N;
    for (int j = 0; j < 8192; j++) exp_q.push_back(8'(j));
    i_ready = 1'b1;
    p0 = pop_cnt;
    h0 = hs_cnt;
    start_stream(9000, s);
    wait_done("t6", 20000);
    chk("t6_pops", pop_cnt - p0, 2048);
    chk("t6_bytes", hs_cnt - h0, 8192);
    chk("t6_cycles", done_cyc - s, 10240);
    chk("t6_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    repeat (6) @(posedge clk);

    // Abort mid-word, then a clean stream
    load2(32'h44332211, 32'h88776655);
    push_word(32'h44332211, 4);
    push_word(32'h88776655, 4);
    i_ready = 1'b1;
    d0 = done_cnt;
    start_stream(8, s);
    wait_byte("t7_first", 8'h11, 20);
    @(posedge clk);
    #1 i_abort = 1'b1;
    i_ready = 1'b0;
    @(posedge clk);
    #1 i_abort = 1'b0;
    @(negedge clk);
    chk("t7_valid", {31'b0, o_valid}, 0);
    chk("t7_fill", {31'b0, o_fill}, 0);
    chk("t7_busy", {31'b0, o_busy}, 0);
    chk("t7_rd", {31'b0, o_fifo_rd}, 0);
    repeat (6) @(posedge clk);
    chk("t7_no_done", done_cnt - d0, 0);
    chk("t7_undelivered", exp_q.size(), 7);
    exp_q.delete();
    i_ready = 1'b1;
    run8("t7b");
    repeat (6) @(posedge clk);

    // Reset mid-word, then a clean stream
    load2(32'h44332211, 32'h88776655);
    push_word(32'h44332211, 4);
    push_word(32'h88776655, 4);
    i_ready = 1'b1;
    d0 = done_cnt;
    start_stream(8, s);
    wait_byte("t8_second", 8'h22, 20);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("t8_valid", {31'b0, o_valid}, 0);
    chk("t8_fill", {31'b0, o_fill}, 0);
    chk("t8_busy", {31'b0, o_busy}, 0);
    chk("t8_rd", {31'b0, o_fifo_rd}, 0);
    chk("t8_data", {24'b0, o_data}, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (6) @(posedge clk);
    chk("t8_no_done", done_cnt - d0, 0);
    chk("t8_undelivered", exp_q.size(), 6);
    exp_q.delete();
    run5("t8b");
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_stream_unpacker.md
SPI_STREAM_UNPACKER -- requirements
Module: spi_stream_unpacker

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 8192, meaning the byte-count ceiling (2048 words of the flash loader buffer).
REQ-002 SHALL have parameter CNT_W, default 14, meaning the width of the byte-count port and internal counter.
REQ-003 SHALL have port clk, input, 1, the single clock, same clock as the flash loader.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_start, input, 1, single-cycle request to begin a stream.
REQ-006 SHALL have port i_abort, input, 1, synchronous abort of the current stream.
REQ-007 SHALL have port i_byte_count, input, CNT_W, the number of bytes to deliver, sampled on accepted i_start.
REQ-008 SHALL have port o_fill, output, 1, fill enable to the loader buffer; deasserting it rewinds the loader read pointer.
REQ-009 SHALL have port i_fifo_empty, input, 1, loader buffer has no valid word.
REQ-010 SHALL have port o_fifo_rd, output, 1, one-cycle pop strobe to the loader buffer.
REQ-011 SHALL have port i_fifo_dout, input, 32, loader word, little-endian (byte 0 in bits 7:0).
REQ-012 SHALL have port o_data, output, 8, the byte output.
REQ-013 SHALL have port o_valid, output, 1, o_data is valid.
REQ-014 SHALL have port i_ready, input, 1, downstream accepts the byte.
REQ-015 SHALL have port o_busy, output, 1, a stream is in progress.
REQ-016 SHALL have port o_done, output, 1, one-cycle pulse when a stream completes.

Function
REQ-017 SHALL implement the states IDLE, FETCH, SHIFT and DONE, all transitions occurring on the rising edge of clk.
REQ-018 IDLE: i_start with count 0 SHALL go to DONE; i_start with count nonzero SHALL latch min(count, MAX_BYTES) into bytes_left, clear byte_idx, and go to FETCH.
REQ-019 FETCH with !i_fifo_empty SHALL, on the next edge, load i_fifo_dout into the shift register, pulse o_fifo_rd for exactly one cycle, set o_valid, and go to SHIFT.
REQ-020 FETCH with i_fifo_empty SHALL hold state, with no pop and no valid.
REQ-021 SHIFT without the handshake (o_valid && i_ready) SHALL hold o_data and o_valid stable.
REQ-022 SHIFT with the handshake SHALL decrement bytes_left and then take the first matching branch of REQ-023 to REQ-025.
REQ-023 If bytes_left was 1, the block SHALL clear o_valid and go to DONE.
REQ-024 Else, if byte_idx was 3, the block SHALL clear o_valid, set byte_idx to 0, and go to FETCH.
REQ-025 Else, the block SHALL shift the register right by 8 and increment byte_idx (2-bit, wraps 3 to 0).
REQ-026 o_data SHALL equal shift-register bits 7:0, so bytes leave LSB first.
REQ-027 DONE SHALL assert o_done for exactly one cycle, then go to IDLE.
REQ-028 o_fill and o_busy SHALL be registered and high exactly while the state is FETCH or SHIFT.
REQ-029 Throughput with i_ready held at 1 SHALL be 4 bytes per 5 cycles, and the first o_valid SHALL appear 1 cycle after FETCH sees !i_fifo_empty.
REQ-030 A partial final word SHALL still be popped once, and its unused bytes SHALL be discarded.
REQ-031 i_start SHALL be ignored outside IDLE.
REQ-032 i_abort SHALL take priority over every other condition and, on the next edge, SHALL go to IDLE and clear o_valid, o_fill, o_busy and o_fifo_rd, without pulsing o_done.
REQ-033 The block SHALL never issue two o_fifo_rd strobes less than 5 cycles apart, because the loader data updates the cycle after a pop.

Reset
REQ-034 resetn low SHALL asynchronously force state IDLE and clear all outputs (o_data, o_valid, o_fill, o_fifo_rd, o_busy, o_done), the shift register, bytes_left and byte_idx.
REQ-035 An assertion of resetn mid-stream SHALL behave as in REQ-034, with no o_done pulse.

Verification
REQ-036 Count 8, words 0x44332211 and 0x88776655, i_ready=1 -> o_data 11,22,33,44,55,66,77,88; 2 o_fifo_rd pulses; o_done 1 cycle after the last handshake; o_fill low afterwards.
REQ-037 Count 5, same words -> bytes 11,22,33,44,55 only; 2 pops; o_valid low after byte 55; o_done pulses once.
REQ-038 Count 8, i_ready low for 3 cycles while byte 22 is presented -> o_data=22 and o_valid=1 held stable; no extra pop; the stream resumes unchanged.
REQ-039 i_fifo_empty held high for 20 cycles after start -> o_fill=1, o_busy=1, no o_fifo_rd, no o_valid; i_fifo_empty then dropped -> first byte valid 1 cycle later.
REQ-040 Count 0 -> o_done high 1 cycle after the start edge, o_fill never set. Count 9000 -> exactly 8192 bytes and 2048 pops.
REQ-041 i_abort, and separately resetn low, asserted mid-word -> o_valid, o_fill, o_busy and o_fifo_rd all 0; o_done never pulses; a new i_start then runs a correct stream.
